instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//   IF stage + IF/ID pipeline register of the 5-stage MIPS core. Holds the PC, fetches from
//   an internal instruction memory (loaded by the debug unit before run), latches {PC+4, instr}
//   into IF/ID. Directly upstream of the hazard unit: consumes its not_load (stall) and halt.
// PARAMETERS
//   PC_WIDTH     32   PC / address width (byte address)
//   INSTR_WIDTH  32   instruction width
//   MEM_DEPTH    64   instruction memory depth in words (power of 2); MEM_AW = clog2(MEM_DEPTH), local
// PORTS
//   i_clk          in   1       system clock, all state on rising edge
//   i_reset        in   1       synchronous, active-high reset
//   i_enable       in   1       debug step/run gate; 0 = freeze all state (memory writes still allowed)
//   i_start        in   1       IDLE->RUN
//   i_not_load     in   1       hazard stall: hold PC and IF/ID
//   i_halt         in   1       HALT opcode currently in ID
//   i_pc_src       in   1       1 = take i_jump_addr (branch/jump resolved in ID)
//   i_jump_addr    in   PC_W    jump/branch target (byte address)
//   i_mem_wr_en    in   1       instruction memory write strobe (IDLE only)
//   i_mem_wr_addr  in   MEM_AW  word address
//   i_mem_wr_data  in   INSTR_W word to write
//   o_pc           out  PC_W    current PC
//   o_if_id_pc4    out  PC_W    IF/ID: PC+4 of latched instruction
//   o_if_id_instr  out  INSTR_W IF/ID: latched instruction
//   o_running      out  1       state == RUN
//   o_halted       out  1       state == HALTED
// BEHAVIOUR
//   Reset: PC=0, IF/ID pc4=0, instr=NOP (32'h0), state=IDLE, o_running=0, o_halted=0.
//     Memory contents NOT cleared by reset.
//   FSM: IDLE --i_start--> RUN --(i_halt & update)--> HALTED; HALTED exits only via i_reset.
//     i_start in RUN/HALTED ignored. i_halt in IDLE ignored.
//   Fetch: word index = PC[MEM_AW+1:2], combinational read; PC bits above MEM_AW+1 ignored
//     (PC wraps mod MEM_DEPTH*4 in effect). PC[1:0] ignored.
//   update = RUN & i_enable & !i_not_load. Per-cycle priority, highest first:
//     1 i_reset; 2 state!=RUN or !i_enable: hold all; 3 i_not_load: hold PC and IF/ID;
//     4 i_halt: state->HALTED, hold PC, IF/ID keeps HALT instr; 5 i_pc_src: PC<=i_jump_addr,
//     IF/ID<=NOP (flush the wrong-path fetch), pc4<=0; 6 else PC<=PC+4,
//     IF/ID<={PC+4, mem[PC]}.
//   Latency: instr at PC appears on o_if_id_instr one cycle after PC is presented (1 cycle).
//   Stall + jump same cycle: stall wins; jump re-resolved when ID re-evaluates next cycle.
//   Halt + jump same cycle: halt wins.
//   PC+4 arithmetic modulo 2^PC_WIDTH; 32'hFFFF_FFFC + 4 -> 0, no flag.
//   Memory write: accepted only when state==IDLE and i_mem_wr_en; written on clock edge;
//     ignored in RUN/HALTED (no error output). Write and i_start same cycle: write lands, RUN
//     begins next cycle reading updated memory.
//   Reset mid-run: next edge returns to reset values; program stays loaded, re-run via i_start.
// STRUCTURE
//   instruction_fetch.vh: CODE_NOP, STATE_IDLE/RUN/HALTED (2-bit encoding), PC_STEP=4.
//   Sub-module instruction_memory (MEM_DEPTH x INSTR_WIDTH, 1 sync write port, 1 async read);
//   FSM, PC register, next-PC mux and IF/ID register in this module.
// TESTING
//   1 Load mem[0..3]={A,B,C,D} in IDLE, pulse i_start -> instr A,B,C,D on o_if_id_instr,
//     pc4 4,8,12,16 in consecutive cycles.
//   2 i_not_load held 2 cycles while instr B latched -> PC=8, IF/ID=B for 2 extra cycles, then C.
//   3 i_pc_src=1, i_jump_addr=0x20 while PC=0x8 -> next IF/ID=NOP, PC=0x20, then mem[8].
//   4 i_halt=1 with HALT in IF/ID -> o_halted=1 next cycle, PC frozen; i_start ignored;
//     i_reset -> PC=0, IDLE.
//   5 Write to mem[5] during RUN -> ignored (read-back after reset shows old value);
//     i_enable=0 for 3 cycles -> all outputs frozen.
//   6 i_not_load & i_pc_src together -> hold; i_halt & i_pc_src together -> HALTED, PC unchanged.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the IF stage: NOP encoding, FSM state codes and PC increment.
package instruction_fetch_pkg;

   localparam logic [31:0] CODE_NOP = 32'h0000_0000;
   localparam int          PC_STEP  = 4;

   localparam logic [1:0] STATE_IDLE   = 2'd0;
   localparam logic [1:0] STATE_RUN    = 2'd1;
   localparam logic [1:0] STATE_HALTED = 2'd2;

endpackage

// File: rtl/instruction_fetch_memory.sv
// Instruction memory: one synchronous write port for program loading, one combinational read port.
module instruction_memory #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Contents survive reset on purpose so a loaded program can be re-run.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS core: PC, run/halt control, instruction memory and the IF/ID register.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int PC_WIDTH    = 32,
   parameter int INSTR_WIDTH = 32,
   parameter int MEM_DEPTH   = 64
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_enable,
   input  logic                          i_start,
   input  logic                          i_not_load,
   input  logic                          i_halt,
   input  logic                          i_pc_src,
   input  logic [PC_WIDTH-1:0]           i_jump_addr,
   input  logic                          i_mem_wr_en,
   input  logic [$clog2(MEM_DEPTH)-1:0]  i_mem_wr_addr,
   input  logic [INSTR_WIDTH-1:0]        i_mem_wr_data,
   output logic [PC_WIDTH-1:0]           o_pc,
   output logic [PC_WIDTH-1:0]           o_if_id_pc4,
   output logic [INSTR_WIDTH-1:0]        o_if_id_instr,
   output logic                          o_running,
   output logic                          o_halted
);

   localparam int MEM_AW = $clog2(MEM_DEPTH);

   logic [1:0]             r_state;
   logic [PC_WIDTH-1:0]    r_pc;
   logic [PC_WIDTH-1:0]    r_pc4;
   logic [INSTR_WIDTH-1:0] r_instr;

   logic [PC_WIDTH-1:0]    w_pcPlus4;
   logic [INSTR_WIDTH-1:0] w_fetch;
   logic                   w_memWrEn;

   // Program loading is only legal while idle; it is not gated by i_enable.
   assign w_memWrEn = (r_state == STATE_IDLE) && i_mem_wr_en;
   assign w_pcPlus4 = r_pc + PC_WIDTH'(PC_STEP);

   instruction_memory #(
      .DEPTH (MEM_DEPTH),
      .WIDTH (INSTR_WIDTH),
      .AW    (MEM_AW)
   ) u_mem (
      .i_clk     (i_clk),
      .i_wr_en   (w_memWrEn),
      .i_wr_addr (i_mem_wr_addr),
      .i_wr_data (i_mem_wr_data),
      .i_rd_addr (r_pc[MEM_AW+1:2]),
      .o_rd_data (w_fetch)
   );

   // Stall beats halt, halt beats a redirect; a redirect flushes the wrong-path fetch to NOP.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= STATE_IDLE;
         r_pc    <= '0;
         r_pc4   <= '0;
         r_instr <= INSTR_WIDTH'(CODE_NOP);
      end else if (i_enable) begin
         case (r_state)
            STATE_IDLE: begin
               if (i_start) begin
                  r_state <= STATE_RUN;
               end
            end
            STATE_RUN: begin
               if (!i_not_load) begin
                  if (i_halt) begin
                     r_state <= STATE_HALTED;
                  end else if (i_pc_src) begin
                     r_pc    <= i_jump_addr;
                     r_pc4   <= '0;
                     r_instr <= INSTR_WIDTH'(CODE_NOP);
                  end else begin
                     r_pc    <= w_pcPlus4;
                     r_pc4   <= w_pcPlus4;
                     r_instr <= w_fetch;
                  end
               end
            end
            default: begin
               r_state <= r_state;
            end
         endcase
      end
   end

   assign o_pc          = r_pc;
   assign o_if_id_pc4   = r_pc4;
   assign o_if_id_instr = r_instr;
   assign o_running     = (r_state == STATE_RUN);
   assign o_halted      = (r_state == STATE_HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed program run followed by randomized control traffic.
module tb_instruction_fetch;

   typedef struct {
      bit          reset;
      bit          enable;
      bit          start;
      bit          notLoad;
      bit          halt;
      bit          pcSrc;
      bit          wrEn;
      logic [31:0] jump;
      logic [5:0]  wrAddr;
      logic [31:0] wrData;
   } stim_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] instr;
      logic        running;
      logic        halted;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, enable, start, notLoad, halt, pcSrc, wrEn;
   logic [31:0] jumpAddr, wrData;
   logic [5:0]  wrAddr;
   logic [31:0] pc, pc4, instr;
   logic        running, halted;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;

   exp_t expQ[$];

   // Behavioural model: program words, PC, IF/ID contents and a mode string.
   logic [31:0] mMem [64];
   logic [31:0] mPc, mPc4, mInstr;
   string       mMode = "idle";

   always #5 clk = ~clk;

   instruction_fetch #(
      .PC_WIDTH    (32),
      .INSTR_WIDTH (32),
      .MEM_DEPTH   (64)
   ) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_enable      (enable),
      .i_start       (start),
      .i_not_load    (notLoad),
      .i_halt        (halt),
      .i_pc_src      (pcSrc),
      .i_jump_addr   (jumpAddr),
      .i_mem_wr_en   (wrEn),
      .i_mem_wr_addr (wrAddr),
      .i_mem_wr_data (wrData),
      .o_pc          (pc),
      .o_if_id_pc4   (pc4),
      .o_if_id_instr (instr),
      .o_running     (running),
      .o_halted      (halted)
   );

   function automatic stim_t defaultStim();
      stim_t s;
      s.reset = 0; s.enable = 1; s.start = 0; s.notLoad = 0; s.halt = 0;
      s.pcSrc = 0; s.wrEn = 0; s.jump = 32'h0; s.wrAddr = 6'd0; s.wrData = 32'h0;
      return s;
   endfunction

   // One clock of the reference behaviour, computed from the pre-edge model state.
   function automatic void modelStep(input stim_t s);
      if (s.reset) begin
         mPc = 0; mPc4 = 0; mInstr = 0; mMode = "idle";
         return;
      end
      if (mMode == "idle" && s.wrEn) mMem[s.wrAddr] = s.wrData;
      if (!s.enable) return;
      if (mMode == "idle") begin
         if (s.start) mMode = "run";
      end else if (mMode == "run" && !s.notLoad) begin
         if (s.halt) begin
            mMode = "halted";
         end else if (s.pcSrc) begin
            mPc = s.jump; mPc4 = 0; mInstr = 0;
         end else begin
            mInstr = mMem[(mPc / 4) % 64];
            mPc    = mPc + 4;
            mPc4   = mPc;
         end
      end
   endfunction

   task automatic applyStimulus(input stim_t s);
      exp_t e;
      @(negedge clk);
      reset = s.reset; enable = s.enable; start = s.start; notLoad = s.notLoad;
      halt = s.halt; pcSrc = s.pcSrc; jumpAddr = s.jump;
      wrEn = s.wrEn; wrAddr = s.wrAddr; wrData = s.wrData;
      modelStep(s);
      e.pc = mPc; e.pc4 = mPc4; e.instr = mInstr;
      e.running = (mMode == "run");
      e.halted  = (mMode == "halted");
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      checks += 5;
      if (pc !== e.pc) begin
         errors++; $display("[TB] FAIL pc cycle=%0d got=%h exp=%h", cycle, pc, e.pc);
      end
      if (pc4 !== e.pc4) begin
         errors++; $display("[TB] FAIL pc4 cycle=%0d got=%h exp=%h", cycle, pc4, e.pc4);
      end
      if (instr !== e.instr) begin
         errors++; $display("[TB] FAIL instr cycle=%0d got=%h exp=%h", cycle, instr, e.instr);
      end
      if (running !== e.running) begin
         errors++; $display("[TB] FAIL running cycle=%0d got=%b exp=%b", cycle, running, e.running);
      end
      if (halted !== e.halted) begin
         errors++; $display("[TB] FAIL halted cycle=%0d got=%b exp=%b", cycle, halted, e.halted);
      end
   endtask

   // Monitor: every edge that follows issued stimulus produces one comparison set.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at cycle=%0d", cycle);
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "[TB] timeout");
   end

   task automatic runCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus(defaultStim());
   endtask

   initial begin
      stim_t s;
      reset = 1; enable = 0; start = 0; notLoad = 0; halt = 0; pcSrc = 0;
      jumpAddr = 0; wrEn = 0; wrAddr = 0; wrData = 0;

      s = defaultStim(); s.reset = 1;
      applyStimulus(s);
      applyStimulus(s);

      // Load the whole memory; words 0..3 are recognisable, the last write coincides with start.
      for (int i = 0; i < 64; i++) begin
         s = defaultStim(); s.wrEn = 1; s.wrAddr = 6'(i);
         s.wrData = (i < 4) ? (32'hA0A0_0000 + 32'(i)) : $urandom;
         s.start = (i == 63);
         applyStimulus(s);
      end
      runCycles(2);

      s = defaultStim(); s.notLoad = 1;
      applyStimulus(s);
      applyStimulus(s);
      runCycles(1);

      s = defaultStim(); s.pcSrc = 1; s.jump = 32'h20;
      applyStimulus(s);
      runCycles(2);

      s = defaultStim(); s.enable = 0; s.pcSrc = 1; s.jump = 32'h40;
      for (int k = 0; k < 3; k++) applyStimulus(s);

      s = defaultStim(); s.notLoad = 1; s.pcSrc = 1; s.jump = 32'h80;
      applyStimulus(s);
      s = defaultStim(); s.halt = 1; s.pcSrc = 1; s.jump = 32'h80;
      applyStimulus(s);

      s = defaultStim(); s.start = 1; s.wrEn = 1; s.wrAddr = 6'd5; s.wrData = 32'hDEAD_BEEF;
      applyStimulus(s);
      runCycles(2);

      s = defaultStim(); s.reset = 1;
      applyStimulus(s);
      s = defaultStim(); s.start = 1;
      applyStimulus(s);
      runCycles(7);

      s = defaultStim(); s.pcSrc = 1; s.jump = 32'hFFFF_FFFC;
      applyStimulus(s);
      runCycles(3);

      s = defaultStim(); s.reset = 1;
      applyStimulus(s);

      // Randomized traffic; the model decides which controls matter in each mode.
      for (int n = 0; n < 800; n++) begin
         s = defaultStim();
         s.reset   = ($urandom_range(0, 79) == 0);
         s.enable  = ($urandom_range(0, 99) < 85);
         s.start   = ($urandom_range(0, 7) == 0);
         s.notLoad = ($urandom_range(0, 4) == 0);
         s.halt    = ($urandom_range(0, 39) == 0);
         s.pcSrc   = ($urandom_range(0, 6) == 0);
         s.jump    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
         s.wrEn    = !s.reset && ($urandom_range(0, 2) == 0);
         s.wrAddr  = 6'($urandom_range(0, 63));
         s.wrData  = $urandom;
         applyStimulus(s);
      end

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain got=%0d pending exp=0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
